// File: rtl/ddram_resp_pkg.sv
// Shared types and constants for the DDRAM responder slice.
package ddram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RLAT  = 2'd2,
        RDATA = 2'd3
    } state_e;

    localparam logic [28:0] DEF_BASE_WORD = 29'h0380_0000;
    localparam int unsigned BEAT_W        = 8;

    // A zero burst count means a single beat.
    function automatic logic [BEAT_W-1:0] burst_last(input logic [7:0] cnt);
        return (cnt == 8'd0) ? 8'd0 : (cnt - 8'd1);
    endfunction

endpackage

// File: rtl/ddram_resp_store.sv
// Byte-enabled single-port 64-bit RAM with a registered, zero-forcible read port.
module ddram_resp_store #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wr_data,
    input  logic [7:0]        wr_be,
    output logic [63:0]       rd_data
);

    logic [63:0] mem_r [2**ADDR_W];
    logic [63:0] q_r;

    // Byte-masked write; contents are intentionally left untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_be[i]) begin
                    mem_r[addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read register holds its value between reads and doubles as the data output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= 64'd0;
        end else if (rd_en) begin
            q_r <= rd_zero ? 64'd0 : mem_r[addr];
        end else begin
            q_r <= q_r;
        end
    end

    assign rd_data = q_r;

endmodule

// File: rtl/ddram_responder.sv
// DDRAM-style burst responder backed by a local store, with a one-deep pending command slot.
// Define DDRAM_RESP_BUSY_INJECT_EN to add LFSR-driven BUSY stalls in IDLE and WRITE.
module ddram_responder
    import ddram_resp_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned READ_LAT  = 3,
    parameter logic [28:0] BASE_WORD = DEF_BASE_WORD
) (
    input  logic        DDRAM_CLK,
    input  logic        DDRAM_RST_N,
    output logic        DDRAM_BUSY,
    input  logic [7:0]  DDRAM_BURSTCNT,
    input  logic [28:0] DDRAM_ADDR,
    output logic [63:0] DDRAM_DOUT,
    output logic        DDRAM_DOUT_READY,
    input  logic        DDRAM_RD,
    input  logic [63:0] DDRAM_DIN,
    input  logic [7:0]  DDRAM_BE,
    input  logic        DDRAM_WE,
    output logic        prot_err
);

    // The store read register adds one cycle, so RLAT counts one short; a pending read
    // is timed from the last-beat edge of the burst it waited behind.
    localparam logic [3:0] LAT_FIRST = 4'(READ_LAT - 1);
    localparam logic [3:0] LAT_PEND  = (READ_LAT > 1) ? 4'(READ_LAT - 2) : 4'd0;

    state_e             state_r, state_n;
    logic [3:0]         lat_r, lat_n;
    logic [BEAT_W-1:0]  beat_r, beat_n, burst_r, burst_n;
    logic [28:0]        base_r, base_n;
    logic               pend_valid_r, pend_valid_n, pend_we_r, pend_we_n;
    logic [28:0]        pend_addr_r, pend_addr_n;
    logic [7:0]         pend_burst_r, pend_burst_n, pend_be_r, pend_be_n;
    logic [63:0]        pend_din_r, pend_din_n;
    logic               busy_r, busy_n, dout_ready_r, prot_err_r;

    logic               acc_s, last_rd_s, use_pend_s, start_s, cap_s, prot_set_s, inject_s;
    logic               cmd_we_s;
    logic [28:0]        cmd_addr_s, cmd_idx_s;
    logic [7:0]         cmd_burst_s, cmd_be_s;
    logic [BEAT_W-1:0]  cmd_last_s;
    logic [63:0]        cmd_din_s, st_din_s, st_dout_s;
    logic               iss_s, st_we_s, oob_s, st_wr_s;
    logic [28:0]        st_idx_s;
    logic [7:0]         st_be_s;

    assign acc_s      = (DDRAM_RD | DDRAM_WE) & ~busy_r;
    assign last_rd_s  = (state_r == RDATA) && (beat_r == burst_r);
    assign use_pend_s = last_rd_s & pend_valid_r;
    assign start_s    = ((state_r == IDLE) & acc_s) | (last_rd_s & (pend_valid_r | acc_s));
    assign cap_s      = (state_r == RDATA) & ~last_rd_s & acc_s;
    assign prot_set_s = (acc_s & DDRAM_RD & DDRAM_WE) |
                        ((state_r == WRITE) & DDRAM_RD & ~busy_r);

    assign cmd_we_s    = use_pend_s ? pend_we_r    : DDRAM_WE;
    assign cmd_addr_s  = use_pend_s ? pend_addr_r  : DDRAM_ADDR;
    assign cmd_burst_s = use_pend_s ? pend_burst_r : DDRAM_BURSTCNT;
    assign cmd_din_s   = use_pend_s ? pend_din_r   : DDRAM_DIN;
    assign cmd_be_s    = use_pend_s ? pend_be_r    : DDRAM_BE;
    assign cmd_idx_s   = cmd_addr_s - BASE_WORD;
    assign cmd_last_s  = burst_last(cmd_burst_s);

`ifdef DDRAM_RESP_BUSY_INJECT_EN
    logic [15:0] lfsr_r, lfsr_n;

    assign lfsr_n   = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    assign inject_s = (lfsr_n[1:0] == 2'b11);

    // Free-running stall generator.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RST_N) begin
        if (!DDRAM_RST_N) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= lfsr_n;
        end
    end
`else
    assign inject_s = 1'b0;
`endif

    // Next-state, store access and pending-slot control.
    always_comb begin
        state_n      = state_r;
        lat_n        = lat_r;
        beat_n       = beat_r;
        burst_n      = burst_r;
        base_n       = base_r;
        pend_valid_n = pend_valid_r;
        pend_we_n    = pend_we_r;
        pend_addr_n  = pend_addr_r;
        pend_burst_n = pend_burst_r;
        pend_din_n   = pend_din_r;
        pend_be_n    = pend_be_r;
        iss_s        = 1'b0;
        st_we_s      = 1'b0;
        st_idx_s     = base_r;
        st_din_s     = DDRAM_DIN;
        st_be_s      = DDRAM_BE;
        case (state_r)
            IDLE: begin
                state_n = IDLE;
            end
            WRITE: begin
                if (DDRAM_WE && !busy_r) begin
                    st_we_s  = 1'b1;
                    st_idx_s = base_r + 29'(beat_r) + 29'd1;
                    beat_n   = beat_r + 8'd1;
                    state_n  = ((beat_r + 8'd1) == burst_r) ? IDLE : WRITE;
                end else begin
                    state_n = WRITE;
                end
            end
            RLAT: begin
                if (lat_r == 4'd0) begin
                    iss_s   = 1'b1;
                    beat_n  = 8'd0;
                    state_n = RDATA;
                end else begin
                    lat_n = lat_r - 4'd1;
                end
            end
            RDATA: begin
                if (!last_rd_s) begin
                    iss_s    = 1'b1;
                    st_idx_s = base_r + 29'(beat_r) + 29'd1;
                    beat_n   = beat_r + 8'd1;
                end else begin
                    state_n = IDLE;
                end
                if (cap_s) begin
                    pend_valid_n = 1'b1;
                    pend_we_n    = DDRAM_WE;
                    pend_addr_n  = DDRAM_ADDR;
                    pend_burst_n = DDRAM_BURSTCNT;
                    pend_din_n   = DDRAM_DIN;
                    pend_be_n    = DDRAM_BE;
                end else begin
                    pend_valid_n = pend_valid_r;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (start_s) begin
            base_n       = cmd_idx_s;
            burst_n      = cmd_last_s;
            beat_n       = 8'd0;
            pend_valid_n = 1'b0;
            if (cmd_we_s) begin
                st_we_s  = 1'b1;
                st_idx_s = cmd_idx_s;
                st_din_s = cmd_din_s;
                st_be_s  = cmd_be_s;
                state_n  = (cmd_last_s == 8'd0) ? IDLE : WRITE;
            end else if (use_pend_s && (READ_LAT == 1)) begin
                iss_s    = 1'b1;
                st_idx_s = cmd_idx_s;
                state_n  = RDATA;
            end else begin
                state_n = RLAT;
                lat_n   = use_pend_s ? LAT_PEND : LAT_FIRST;
            end
        end else begin
            base_n = base_n;
        end
    end

    assign oob_s   = |st_idx_s[28:ADDR_W];
    assign st_wr_s = st_we_s & ~oob_s;

    // BUSY is registered from next-state so it is glitch-free and clears at once on reset.
    always_comb begin
        busy_n = (state_n == RLAT) | ((state_n == RDATA) & pend_valid_n) |
                 (((state_n == IDLE) | (state_n == WRITE)) & inject_s);
    end

    // Control and output registers.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RST_N) begin
        if (!DDRAM_RST_N) begin
            state_r      <= IDLE;
            lat_r        <= 4'd0;
            beat_r       <= 8'd0;
            burst_r      <= 8'd0;
            base_r       <= 29'd0;
            pend_valid_r <= 1'b0;
            pend_we_r    <= 1'b0;
            pend_addr_r  <= 29'd0;
            pend_burst_r <= 8'd0;
            pend_din_r   <= 64'd0;
            pend_be_r    <= 8'd0;
            busy_r       <= 1'b0;
            dout_ready_r <= 1'b0;
            prot_err_r   <= 1'b0;
        end else begin
            state_r      <= state_n;
            lat_r        <= lat_n;
            beat_r       <= beat_n;
            burst_r      <= burst_n;
            base_r       <= base_n;
            pend_valid_r <= pend_valid_n;
            pend_we_r    <= pend_we_n;
            pend_addr_r  <= pend_addr_n;
            pend_burst_r <= pend_burst_n;
            pend_din_r   <= pend_din_n;
            pend_be_r    <= pend_be_n;
            busy_r       <= busy_n;
            dout_ready_r <= iss_s;
            prot_err_r   <= prot_err_r | prot_set_s;
        end
    end

    ddram_resp_store #(.ADDR_W(ADDR_W)) u_store (
        .clk     (DDRAM_CLK),
        .rst_n   (DDRAM_RST_N),
        .wr_en   (st_wr_s),
        .rd_en   (iss_s),
        .rd_zero (oob_s),
        .addr    (st_idx_s[ADDR_W-1:0]),
        .wr_data (st_din_s),
        .wr_be   (st_be_s),
        .rd_data (st_dout_s)
    );

    assign DDRAM_BUSY       = busy_r;
    assign DDRAM_DOUT_READY = dout_ready_r;
    assign DDRAM_DOUT       = st_dout_s;
    assign prot_err         = prot_err_r;

endmodule

// File: tb/tb_ddram_responder.sv
// Directed self-checking bench for ddram_responder (default build, READ_LAT=3).
module tb_ddram_responder;

    localparam logic [28:0] BW = 29'h0380_0000;

    logic        clk = 1'b0;
    logic        rst_n, busy, rdy, rd, we, perr;
    logic [7:0]  burst, be;
    logic [28:0] addr;
    logic [63:0] din, dout;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] wdat [0:7];

    ddram_responder #(.ADDR_W(12), .READ_LAT(3), .BASE_WORD(BW)) dut (
        .DDRAM_CLK        (clk),
        .DDRAM_RST_N      (rst_n),
        .DDRAM_BUSY       (busy),
        .DDRAM_BURSTCNT   (burst),
        .DDRAM_ADDR       (addr),
        .DDRAM_DOUT       (dout),
        .DDRAM_DOUT_READY (rdy),
        .DDRAM_RD         (rd),
        .DDRAM_DIN        (din),
        .DDRAM_BE         (be),
        .DDRAM_WE         (we),
        .prot_err         (perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue_rd(input logic [28:0] a, input logic [7:0] n);
        @(negedge clk);
        rd = 1'b1; we = 1'b0; addr = a; burst = n;
    endtask

    // Cycle k samples the k-th falling edge after the command was driven.
    task automatic watch(input string tag, input int ncyc, input logic [31:0] rdy_m,
                         input logic [31:0] busy_m, input int inj_k,
                         input logic [28:0] inj_a, input logic [7:0] inj_n);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            chk($sformatf("%s_rdy%0d", tag, k), 64'(rdy), 64'(rdy_m[k]));
            chk($sformatf("%s_busy%0d", tag, k), 64'(busy), 64'(busy_m[k]));
            if (rdy_m[k] && exp_q.size() > 0) begin
                chk($sformatf("%s_data%0d", tag, k), dout, exp_q.pop_front());
            end
            we = 1'b0;
            if (k == inj_k) begin
                rd = 1'b1; addr = inj_a; burst = inj_n;
            end else begin
                rd = 1'b0;
            end
        end
    endtask

    task automatic wr_burst(input string tag, input logic [28:0] a, input int n, input logic [7:0] b);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_busy%0d", tag, i), 64'(busy), 64'd0);
            we = 1'b1; rd = 1'b0; din = wdat[i]; be = b;
            addr  = (i == 0) ? a : ~a;
            burst = (i == 0) ? 8'(n) : 8'hFF;
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rd = 1'b0; we = 1'b0; addr = 29'd0; burst = 8'd0; din = 64'd0; be = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdy", 64'(rdy), 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_perr", 64'(perr), 64'd0);
        rst_n = 1'b1;

        // full write then single-beat read, latency 3
        wdat[0] = 64'h1122334455667788;
        wr_burst("s1w", BW + 29'd5, 1, 8'hFF);
        exp_q.push_back(64'h1122334455667788);
        issue_rd(BW + 29'd5, 8'd1);
        watch("s1r", 6, 32'h10, 32'hE, 0, 29'd0, 8'd0);
        chk("s1_hold", dout, 64'h1122334455667788);

        // partial byte-enable write
        wdat[0] = 64'hFFFFFFFF_AAAAAAAA;
        wr_burst("s2w", BW + 29'd5, 1, 8'h0F);
        exp_q.push_back(64'h11223344_AAAAAAAA);
        issue_rd(BW + 29'd5, 8'd1);
        watch("s2r", 6, 32'h10, 32'hE, 0, 29'd0, 8'd0);

        // burst-4 write and read back
        for (int i = 0; i < 4; i++) wdat[i] = 64'(i + 1);
        wr_burst("s3w", BW, 4, 8'hFF);
        for (int i = 1; i <= 4; i++) exp_q.push_back(64'(i));
        issue_rd(BW, 8'd4);
        watch("s3r", 9, 32'hF0, 32'hE, 0, 29'd0, 8'd0);

        // read issued during the first RDATA beat is held pending
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd2);
        exp_q.push_back(64'h11223344_AAAAAAAA);
        issue_rd(BW, 8'd2);
        watch("s4r", 10, 32'h130, 32'hEE, 4, BW + 29'd5, 8'd1);
        chk("s4_perr", 64'(perr), 64'd0);

        // out-of-range beats and zero burst count
        wdat[0] = 64'hCAFEF00D_00000001;
        wr_burst("o1w", BW + 29'd4095, 1, 8'hFF);
        wdat[0] = 64'h55555555_55555555;
        wr_burst("o2w", BW + 29'd4096, 1, 8'hFF);
        wr_burst("o3w", BW - 29'd1, 1, 8'hFF);
        exp_q.push_back(64'hCAFEF00D_00000001);
        exp_q.push_back(64'd0);
        issue_rd(BW + 29'd4095, 8'd2);
        watch("o4r", 7, 32'h30, 32'hE, 0, 29'd0, 8'd0);
        exp_q.push_back(64'd1);
        issue_rd(BW, 8'd0);
        watch("o5r", 7, 32'h10, 32'hE, 0, 29'd0, 8'd0);

        // RD and WE together: write wins, sticky error
        @(negedge clk);
        rd = 1'b1; we = 1'b1; addr = BW + 29'd7; din = 64'hDEADBEEF_01234567; be = 8'hFF; burst = 8'd1;
        watch("s5", 5, 32'h0, 32'h0, 0, 29'd0, 8'd0);
        chk("s5_perr", 64'(perr), 64'd1);
        exp_q.push_back(64'hDEADBEEF_01234567);
        issue_rd(BW + 29'd7, 8'd1);
        watch("s5r", 6, 32'h10, 32'hE, 0, 29'd0, 8'd0);
        chk("s5_perr_hold", 64'(perr), 64'd1);

        // reset during beat 2 of a burst-8 read
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd2);
        issue_rd(BW, 8'd8);
        watch("s6a", 5, 32'h30, 32'hE, 0, 29'd0, 8'd0);
        rst_n = 1'b0;
        #1;
        chk("s6_rdy", 64'(rdy), 64'd0);
        chk("s6_busy", 64'(busy), 64'd0);
        chk("s6_dout", dout, 64'd0);
        chk("s6_perr", 64'(perr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch("s6b", 10, 32'h0, 32'h0, 0, 29'd0, 8'd0);
        exp_q.push_back(64'h11223344_AAAAAAAA);
        issue_rd(BW + 29'd5, 8'd1);
        watch("s6r", 6, 32'h10, 32'hE, 0, 29'd0, 8'd0);

        // RD during a write burst is flagged and ignored
        @(negedge clk);
        we = 1'b1; rd = 1'b0; addr = BW + 29'd20; din = 64'hA1; be = 8'hFF; burst = 8'd2;
        @(negedge clk);
        we = 1'b0; rd = 1'b1; addr = BW + 29'd30; burst = 8'd1;
        @(negedge clk);
        chk("rw_busy", 64'(busy), 64'd0);
        we = 1'b1; rd = 1'b0; addr = 29'd0; din = 64'hA2;
        watch("rw", 5, 32'h0, 32'h0, 0, 29'd0, 8'd0);
        chk("rw_perr", 64'(perr), 64'd1);
        exp_q.push_back(64'hA1);
        exp_q.push_back(64'hA2);
        issue_rd(BW + 29'd20, 8'd2);
        watch("rwr", 7, 32'h30, 32'hE, 0, 29'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddram_responder.md
DDRAM_RESPONDER -- requirements
Module: ddram_responder

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 12, meaning log2 of backing-store depth in 64-bit words.
REQ-002 The module SHALL have parameter READ_LAT, default 3, meaning cycles from read acceptance to the first data beat, legal range 1..15.
REQ-003 The module SHALL have parameter BASE_WORD, default 29'h0380_0000, meaning the 29-bit word address of store word 0.
REQ-004 Ports, in order:
- DDRAM_CLK  in  1  single clock.
- DDRAM_RST_N  in  1  asynchronous active-low reset.
- DDRAM_BUSY  out  1  command wait.
- DDRAM_BURSTCNT  in  8  beats per command.
- DDRAM_ADDR  in  29  word address.
- DDRAM_DOUT  out  64  read data.
- DDRAM_DOUT_READY  out  1  read beat valid.
- DDRAM_RD  in  1  read request.
- DDRAM_DIN  in  64  write data.
- DDRAM_BE  in  8  write byte enables.
- DDRAM_WE  in  1  write request/beat.
- prot_err  out  1  sticky protocol-error flag.
REQ-005 Reset SHALL be asynchronous and active-low, and all logic SHALL be clocked on DDRAM_CLK only.

Function
REQ-006 A command or write beat SHALL be accepted on a rising edge where (DDRAM_RD or DDRAM_WE) is high and DDRAM_BUSY is low.
REQ-007 FSM states SHALL be IDLE, WRITE, RLAT and RDATA.
- IDLE→WRITE on an accepted WE with BURSTCNT>1.
- IDLE→RLAT on an accepted RD.
- RLAT→RDATA when the latency counter expires.
- RDATA→IDLE, or to the pending command, after the last beat.
- WRITE→IDLE after the last beat.
REQ-008 BURSTCNT==0 SHALL be treated as 1.
REQ-009 Store index SHALL be (DDRAM_ADDR − BASE_WORD), the beat offset SHALL be added per beat, and the arithmetic SHALL be 29 bits wide.
REQ-010 A beat whose index is ≥ 2^ADDR_W SHALL return zero data on read and be dropped on write.
REQ-011 Writes SHALL update only the bytes whose DDRAM_BE bit is 1.
REQ-012 In WRITE, beat n SHALL be written at base+n, address/BURSTCNT SHALL be ignored after the first beat, and BUSY SHALL be low.
REQ-013 In RLAT, BUSY SHALL be high, and the first DOUT_READY SHALL assert exactly READ_LAT cycles after the acceptance edge.
REQ-014 In RDATA, beats SHALL be back-to-back, one per cycle, with DOUT_READY high for exactly BURSTCNT cycles.
REQ-015 BUSY SHALL be low during RDATA unless a pending command is held.
REQ-016 A command accepted in RDATA SHALL be captured in a one-deep pending register, and BUSY SHALL be high from the next cycle until the pending command starts.
REQ-017 A pending command SHALL start in the cycle after the last read beat.
REQ-018 A write issued after a read to the same address SHALL NOT affect data already returned, and a read issued after a write SHALL see the written data.
REQ-019 If RD and WE are both high on an acceptance edge, the write SHALL win, the read SHALL be dropped, and prot_err SHALL be set.
REQ-020 An RD in WRITE state SHALL set prot_err and be ignored.
REQ-021 DDRAM_DOUT SHALL hold its last value when DOUT_READY is low.

Reset
REQ-022 On reset assertion the following SHALL hold immediately:
- FSM = IDLE
- DDRAM_BUSY = 0
- DDRAM_DOUT_READY = 0
- DDRAM_DOUT = 0
- prot_err = 0
- pending register invalid
- counters = 0
REQ-023 Store contents SHALL NOT be cleared by reset.
REQ-024 Reset asserted mid-burst SHALL abort the burst with no further beats, and any remaining write beats SHALL be discarded.

Configuration
REQ-025 With DDRAM_RESP_BUSY_INJECT_EN defined, a 16-bit LFSR (seed 16'hACE1, stepping every cycle) SHALL force BUSY high in IDLE and WRITE whenever its two LSBs are 2'b11.
REQ-026 Without DDRAM_RESP_BUSY_INJECT_EN, BUSY SHALL follow REQ-012 through REQ-016 only, and no LFSR logic SHALL be present.

Structure
REQ-027 Package ddram_resp_pkg SHALL hold the FSM state enum, the default BASE_WORD constant and the beat-counter width.
REQ-028 Sub-module ddram_resp_store SHALL implement the byte-enabled single-port 64-bit RAM with registered read, and the FSM SHALL absorb its one-cycle read latency within READ_LAT.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Write 64'h1122334455667788 at BASE_WORD+5 with BE=8'hFF, then read burst 1 → one DOUT_READY with that value, exactly 3 cycles after acceptance.
- Write BE=8'h0F with 64'hFFFFFFFF_AAAAAAAA over the previous word → read returns 64'h11223344_AAAAAAAA.
- Write burst 4 at BASE_WORD with values 1..4, then read burst 4 → four consecutive beats 1,2,3,4; BUSY high only during RLAT.
- Read burst 2 and, in the first RDATA cycle, issue read burst 1 → it is captured, BUSY rises next cycle, and its beat arrives READ_LAT cycles after the last beat of the first read.
- RD and WE both high with BUSY low → write performed, no DOUT_READY, prot_err=1 until reset.
- Reset asserted during beat 2 of a burst-8 read → DOUT_READY=0 and BUSY=0 immediately, and no further beats appear.
